// File: rtl/membus_pkg.sv
// Shared types for the two-master memory front end.
//   ArbState : arbiter occupancy (idle, or which master owns the in-flight access)
//   Owner    : identifies a master; OWN_I = instruction fetch, OWN_D = load/store
package membus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } ArbState;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } Owner;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin picker, purely combinational.
//   req[0]      : fetch master requesting
//   req[1]      : load/store master requesting
//   last        : master granted most recently (state held by the caller)
//   grant_valid : at least one request present
//   grant       : chosen master; on a tie, the one not granted last time
module arb_rr2
  import membus_pkg::*;
(
  input  logic [1:0] req,
  input  Owner       last,
  output logic       grant_valid,
  output Owner       grant
);

  always_comb begin
    grant_valid = |req;
    grant       = OWN_I;
    case (req)
      2'b10:   grant = OWN_D;
      2'b11:   grant = (last == OWN_I) ? OWN_D : OWN_I;
      default: grant = OWN_I;
    endcase
  end

endmodule

// File: rtl/memory_arbiter.sv
// Two-master front end for a single-port memory: fetch (i_*) and load/store (d_*).
// Round-robin picks a requester, forwards it to the memory request port and tracks
// the single outstanding access so the response pulse is routed to its owner.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   i_valid/i_ready/i_addr           fetch request handshake
//   i_rvalid/i_rdata                 fetch response
//   d_valid/d_ready/d_wen/d_addr/
//   d_wdata/d_wmask                  load/store request handshake
//   d_rvalid/d_rdata                 load/store completion (stores pulse too)
//   mem_ready/mem_valid/mem_wen/
//   mem_addr/mem_wdata/mem_wmask     memory request port
//   mem_rvalid/mem_rdata             memory response
module memory_arbiter
  import membus_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  output logic                    i_ready,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  output logic                    i_rvalid,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  input  logic                    d_valid,
  output logic                    d_ready,
  input  logic                    d_wen,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wmask,
  output logic                    d_rvalid,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  input  logic                    mem_ready,
  output logic                    mem_valid,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wmask,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  ArbState state, state_nxt;
  Owner    last_grant, last_nxt;
  Owner    pick;
  logic    pick_valid;
  logic    can_issue;
  logic    accept;

  arb_rr2 u_pick (
    .req         ({d_valid, i_valid}),
    .last        (last_grant),
    .grant_valid (pick_valid),
    .grant       (pick)
  );

  // Request side: a new access may go out while idle, or in the very cycle the
  // outstanding one completes, which gives back-to-back reads.
  always_comb begin
    can_issue = mem_ready & ((state == IDLE) | mem_rvalid);
    mem_valid = ~rst & can_issue & pick_valid;
    accept    = mem_valid & mem_ready;
    i_ready   = mem_valid & (pick == OWN_I);
    d_ready   = mem_valid & (pick == OWN_D);

    // Fetch never writes, so its write fields are forced to zero.
    mem_wen   = 1'b0;
    mem_addr  = i_addr;
    mem_wdata = '0;
    mem_wmask = '0;
    if (pick == OWN_D) begin
      mem_wen   = d_wen;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
      mem_wmask = d_wmask;
    end
  end

  // Response side: routed by current owner; a pulse with no owner is dropped.
  always_comb begin
    i_rvalid = ~rst & mem_rvalid & (state == BUSY_I);
    d_rvalid = ~rst & mem_rvalid & (state == BUSY_D);
    i_rdata  = mem_rdata;
    d_rdata  = mem_rdata;
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    if (accept) begin
      state_nxt = (pick == OWN_I) ? BUSY_I : BUSY_D;
      last_nxt  = pick;
    end else if ((state != IDLE) && mem_rvalid) begin
      state_nxt = IDLE;
    end
  end

  // last_grant resets to D so that I wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= OWN_D;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: cycle vectors in a table, plus hand sequences for
// continuous contention and reset during an outstanding write. Includes a small
// behavioural memory obeying the read/write response timing contract.
module tb_memory_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, i_rvalid;
  logic [15:0] i_addr;
  logic [63:0] i_rdata;
  logic        d_valid, d_ready, d_wen, d_rvalid;
  logic [15:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        mem_ready, mem_valid, mem_wen, mem_rvalid;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  memory_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_ready(i_ready), .i_addr(i_addr),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_ready(d_ready), .d_wen(d_wen), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wmask(d_wmask), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_ready(mem_ready), .mem_valid(mem_valid), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  // ---------------- behavioural memory ----------------
  logic        rd_p, wr_p1, wr_p2, force_rv;
  logic [63:0] rdata_q;
  logic [63:0] marr  [0:255];
  logic        mflag [0:255];

  // Contents of never-written words.
  function automatic logic [63:0] pattern(input logic [15:0] a);
    if (a == 16'h0010) return 64'h0000_0000_0000_00AA;
    return {16'hBEEF, 32'h0, a};
  endfunction

  function logic [63:0] cur(input logic [15:0] a);
    return mflag[a[7:0]] ? marr[a[7:0]] : pattern(a);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                        input logic [7:0] m);
    logic [63:0] r;
    r = old;
    for (int b = 0; b < 8; b++) if (m[b]) r[b*8 +: 8] = nw[b*8 +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      rd_p  <= 1'b0;
      wr_p1 <= 1'b0;
      wr_p2 <= 1'b0;
      for (int k = 0; k < 256; k++) mflag[k] <= 1'b0;
    end else begin
      rd_p  <= mem_valid & mem_ready & ~mem_wen;
      wr_p1 <= mem_valid & mem_ready & mem_wen;
      wr_p2 <= wr_p1;
      if (mem_valid & mem_ready) begin
        if (mem_wen) begin
          marr[mem_addr[7:0]]  <= merge(cur(mem_addr), mem_wdata, mem_wmask);
          mflag[mem_addr[7:0]] <= 1'b1;
        end else begin
          rdata_q <= cur(mem_addr);
        end
      end
    end
  end

  assign mem_ready  = ~wr_p1;
  assign mem_rvalid = rd_p | wr_p2 | force_rv;
  assign mem_rdata  = force_rv ? 64'h0000_0000_0000_DEAD : rdata_q;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic apply(input logic r, input logic iv, input logic [15:0] ia,
                       input logic dv, input logic dw, input logic [15:0] da,
                       input logic [63:0] wd, input logic [7:0] wm, input logic frc);
    rst = r; i_valid = iv; i_addr = ia; d_valid = dv; d_wen = dw;
    d_addr = da; d_wdata = wd; d_wmask = wm; force_rv = frc;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        r, iv;
    logic [15:0] ia;
    logic        dv, dw;
    logic [15:0] da;
    logic [63:0] wd;
    logic [7:0]  wm;
    logic        frc;
    logic        ir, dr, irv, drv, mv;
    logic        chk_rd;
    logic [63:0] rd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic iv, input logic [15:0] ia,
                              input logic dv, input logic dw, input logic [15:0] da,
                              input logic [63:0] wd, input logic [7:0] wm, input logic frc,
                              input logic ir, input logic dr, input logic irv,
                              input logic drv, input logic mv,
                              input logic chk_rd, input logic [63:0] rd);
    vec_t v;
    v.r = r; v.iv = iv; v.ia = ia; v.dv = dv; v.dw = dw; v.da = da; v.wd = wd;
    v.wm = wm; v.frc = frc; v.ir = ir; v.dr = dr; v.irv = irv; v.drv = drv;
    v.mv = mv; v.chk_rd = chk_rd; v.rd = rd;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin : watchdog
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit          prev_i;
    logic [15:0] prev_a;
    int          ni, nd, nresp;
    bit          exp_i;

    apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b0);
    next_cycle();

    //           r  iv ia       dv dw da      wd                      wm     frc  ir dr irv drv mv chk rd
    tbl[0]  = mk(1, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  0,  0, 0, 64'h0);
    tbl[1]  = mk(1, 1, 16'h10,  1, 0, 16'h20, 64'h0,                  8'h00, 0,   0, 0, 0,  0,  0, 0, 64'h0);
    tbl[2]  = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  0,  0, 0, 64'h0);
    tbl[3]  = mk(0, 1, 16'h10,  0, 0, 16'h0,  64'h0,                  8'h00, 0,   1, 0, 0,  0,  1, 0, 64'h0);
    tbl[4]  = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 1,  0,  0, 1, 64'hAA);
    tbl[5]  = mk(1, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  0,  0, 0, 64'h0);
    tbl[6]  = mk(0, 1, 16'h10,  1, 0, 16'h20, 64'h0,                  8'h00, 0,   1, 0, 0,  0,  1, 0, 64'h0);
    tbl[7]  = mk(0, 0, 16'h10,  1, 0, 16'h20, 64'h0,                  8'h00, 0,   0, 1, 1,  0,  1, 1, 64'hAA);
    tbl[8]  = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  1,  0, 1, 64'hBEEF_0000_0000_0020);
    tbl[9]  = mk(0, 0, 16'h0,   1, 1, 16'h5,  64'h1122334455667788,   8'h0F, 0,   0, 1, 0,  0,  1, 0, 64'h0);
    tbl[10] = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  0,  0, 0, 64'h0);
    tbl[11] = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  1,  0, 0, 64'h0);
    tbl[12] = mk(0, 0, 16'h0,   1, 0, 16'h5,  64'h0,                  8'h00, 0,   0, 1, 0,  0,  1, 0, 64'h0);
    tbl[13] = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 0,   0, 0, 0,  1,  0, 1, 64'hBEEF_0000_5566_7788);
    tbl[14] = mk(0, 0, 16'h0,   0, 0, 16'h0,  64'h0,                  8'h00, 1,   0, 0, 0,  0,  0, 0, 64'h0);

    for (int r = 0; r < 15; r++) begin
      apply(tbl[r].r, tbl[r].iv, tbl[r].ia, tbl[r].dv, tbl[r].dw, tbl[r].da,
            tbl[r].wd, tbl[r].wm, tbl[r].frc);
      @(negedge clk);
      chk($sformatf("row%0d i_ready", r),   {63'h0, i_ready},   {63'h0, tbl[r].ir});
      chk($sformatf("row%0d d_ready", r),   {63'h0, d_ready},   {63'h0, tbl[r].dr});
      chk($sformatf("row%0d i_rvalid", r),  {63'h0, i_rvalid},  {63'h0, tbl[r].irv});
      chk($sformatf("row%0d d_rvalid", r),  {63'h0, d_rvalid},  {63'h0, tbl[r].drv});
      chk($sformatf("row%0d mem_valid", r), {63'h0, mem_valid}, {63'h0, tbl[r].mv});
      if (tbl[r].chk_rd) begin
        if (tbl[r].irv) chk($sformatf("row%0d i_rdata", r), i_rdata, tbl[r].rd);
        else            chk($sformatf("row%0d d_rdata", r), d_rdata, tbl[r].rd);
      end
      next_cycle();
    end

    // Continuous contention: both ports read every cycle for 20 grants.
    apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b0);
    next_cycle();
    ni = 0; nd = 0; nresp = 0; prev_i = 1'b0; prev_a = 16'h0;
    for (int k = 0; k <= 20; k++) begin
      apply(1'b0, k < 20, 16'h0100 + 16'(ni), k < 20, 1'b0, 16'h0200 + 16'(nd),
            64'h0, 8'h0, 1'b0);
      @(negedge clk);
      if (k >= 1) begin
        chk($sformatf("cont%0d i_rvalid", k), {63'h0, i_rvalid}, {63'h0, prev_i});
        chk($sformatf("cont%0d d_rvalid", k), {63'h0, d_rvalid}, {63'h0, ~prev_i});
        chk($sformatf("cont%0d rdata", k), prev_i ? i_rdata : d_rdata, pattern(prev_a));
      end
      if (i_rvalid | d_rvalid) nresp++;
      if (k < 20) begin
        exp_i = (k % 2) == 0;
        chk($sformatf("cont%0d i_ready", k), {63'h0, i_ready}, {63'h0, exp_i});
        chk($sformatf("cont%0d d_ready", k), {63'h0, d_ready}, {63'h0, ~exp_i});
        prev_i = exp_i;
        prev_a = exp_i ? 16'h0100 + 16'(ni) : 16'h0200 + 16'(nd);
        if (i_ready) ni++;
        if (d_ready) nd++;
      end
      next_cycle();
    end
    chk("cont responses", 64'(nresp), 64'd20);

    // Reset one cycle after a store is accepted: the store's completion is dropped.
    apply(1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 16'h7, 64'h0123, 8'hFF, 1'b0);
    @(negedge clk);
    chk("rstmid store accept", {63'h0, d_ready}, 64'd1);
    next_cycle();
    apply(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b0);
    @(negedge clk);
    chk("rstmid d_rvalid in reset", {63'h0, d_rvalid}, 64'd0);
    next_cycle();
    apply(1'b0, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0030, 64'h0, 8'h0, 1'b0);
    @(negedge clk);
    chk("rstmid d_rvalid after", {63'h0, d_rvalid}, 64'd0);
    chk("rstmid tie i_ready", {63'h0, i_ready}, 64'd1);
    chk("rstmid tie d_ready", {63'h0, d_ready}, 64'd0);
    next_cycle();
    apply(1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 16'h0030, 64'h0, 8'h0, 1'b0);
    @(negedge clk);
    chk("rstmid i_rvalid", {63'h0, i_rvalid}, 64'd1);
    chk("rstmid i_rdata", i_rdata, 64'hAA);
    chk("rstmid d_ready", {63'h0, d_ready}, 64'd1);
    next_cycle();
    apply(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 64'h0, 8'h0, 1'b0);
    @(negedge clk);
    chk("rstmid d_rvalid load", {63'h0, d_rvalid}, 64'd1);
    chk("rstmid d_rdata", d_rdata, 64'hBEEF_0000_0000_0030);
    next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
